packet_builder: RTL and testbench

- Processing stage between the input-memory read channel and the output-memory write channel.
- On a start command, it fetches an input packet of byte_cnt+1 payload bytes over the read channel, unpacking 1, 2 or 4 bytes per beat according to data_sel.
- It then emits a packed output packet on the write channel, little-endian at 4 bytes per beat: 2 header bytes, then the payload, then a CRC-8.
- The data-integrity checker relies on this layout: payload byte i lands at output byte i+2.

---
 rtl/pkt_pkg.sv | 31 +++
 rtl/packet_builder_if.sv | 28 ++
 rtl/crc8_word.sv | 18 +
 rtl/packet_builder.sv | 158 +++++++++++++++
 tb/tb_packet_builder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_pkg.sv
// Shared constants, FSM state type and the bytewise CRC-8 helper for packet_builder.
package pkt_pkg;

  localparam logic [3:0] OP0 = 4'd0;
  localparam logic [3:0] OP1 = 4'd1;
  localparam logic [3:0] OP2 = 4'd2;

  localparam logic [7:0]  CRC_POLY      = 8'h07;
  localparam int unsigned MAX_PAYLOAD   = 16;
  localparam int unsigned HDR_LEN       = 2;
  localparam int unsigned CRC_LEN       = 1;
  localparam int unsigned MAX_OUT_BYTES = 19;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  // MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_builder_if.sv
// Command, status, read-channel and write-channel signals of packet_builder.
interface packet_builder_if;
  logic        start;
  logic [3:0]  byte_cnt;
  logic [3:0]  data_sel;
  logic [7:0]  pkt_id;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wlast;
  logic        wready;
  logic        err;

  modport master (
    input  start, byte_cnt, data_sel, pkt_id, rdata, rvalid, rlast, wready,
    output busy, done, rready, wdata, wvalid, wlast, err
  );

  modport slave (
    output start, byte_cnt, data_sel, pkt_id, rdata, rvalid, rlast, wready,
    input  busy, done, rready, wdata, wvalid, wlast, err
  );
endinterface

// File: rtl/crc8_word.sv
// Combinational CRC-8 update over the low nbytes_i lanes (lane 0 first) of a 32-bit word.
module crc8_word
  import pkt_pkg::*;
(
  input  logic [7:0]  crc_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [7:0]  crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes_i) crc_o = crc8_update(crc_o, data_i[8*k +: 8]);
    end
  end

endmodule

// File: rtl/packet_builder.sv
// Reads a payload, emits {hdr0, hdr1, payload, crc8} packed 4 bytes/beat.
// Optional rlast cross-check enabled by macro PB_RLAST_CHECK_EN.
module packet_builder
  import pkt_pkg::*;
(
  input logic            clk,
  input logic            reset,
  packet_builder_if.master bus
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  wbeat_q, wbeat_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  pkt_buf_q [MAX_OUT_BYTES];
  logic [7:0]  pkt_buf_d [MAX_OUT_BYTES];

  logic [2:0]  bpb;
  logic [4:0]  rem;
  logic [2:0]  nbytes;
  logic        last_beat;
  logic [5:0]  idx_sum;
  logic [7:0]  crc_word;
  logic [4:0]  total;
  logic [4:0]  widx;

  always_comb begin
    unique case (sel_q)
      OP0:     bpb = 3'd1;
      OP1:     bpb = 3'd2;
      default: bpb = 3'd4;
    endcase
    // Payload bytes still owed: (cnt+1) - (idx-HDR_LEN).
    rem       = 5'(cnt_q) + 5'd3 - idx_q;
    last_beat = (rem <= 5'(bpb));
    nbytes    = last_beat ? rem[2:0] : bpb;
    idx_sum   = {1'b0, idx_q} + {3'b000, nbytes};
    total     = 5'(cnt_q) + 5'd4;
  end

  crc8_word u_crc8_word (
    .crc_i   (crc_q),
    .data_i  (bus.rdata),
    .nbytes_i(nbytes),
    .crc_o   (crc_word)
  );

`ifdef PB_RLAST_CHECK_EN
  logic err_q, err_d;
  assign bus.err = err_q;
`else
  logic unused_rlast;
  assign unused_rlast = bus.rlast;
  assign bus.err      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    wbeat_d    = wbeat_q;
    crc_d      = crc_q;
    pkt_buf_d  = pkt_buf_q;
    widx       = '0;
`ifdef PB_RLAST_CHECK_EN
    err_d      = err_q;
`endif
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.rready = 1'b0;
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.wdata  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StRead;
          cnt_d        = bus.byte_cnt;
          sel_d        = bus.data_sel;
          idx_d        = 5'(HDR_LEN);
          pkt_buf_d[0] = {bus.data_sel, bus.byte_cnt};
          pkt_buf_d[1] = bus.pkt_id;
          crc_d        = crc8_update(crc8_update(8'h00, {bus.data_sel, bus.byte_cnt}),
                                     bus.pkt_id);
        end
      end
      StRead: begin
        bus.busy   = 1'b1;
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes) pkt_buf_d[idx_q + 5'(k)] = bus.rdata[8*k +: 8];
          end
          crc_d = crc_word;
          idx_d = (idx_sum > 6'(MAX_OUT_BYTES)) ? 5'(MAX_OUT_BYTES) : idx_sum[4:0];
`ifdef PB_RLAST_CHECK_EN
          if (bus.rlast != last_beat) err_d = 1'b1;
`endif
          if (last_beat) begin
            pkt_buf_d[5'(cnt_q) + 5'd3] = crc_word;
            wbeat_d = '0;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        bus.busy   = 1'b1;
        bus.wvalid = 1'b1;
        bus.wlast  = (({2'b00, wbeat_q} + 5'd1) == ((5'(cnt_q) + 5'd7) >> 2));
        // Lanes at or past the packet length read as zero, not stale buffer contents.
        for (int l = 0; l < 4; l++) begin
          widx = {wbeat_q, 2'b00} + 5'(l);
          if (widx < total) bus.wdata[8*l +: 8] = pkt_buf_q[widx];
        end
        if (bus.wready) begin
          if (bus.wlast) state_d = StDone;
          else           wbeat_d = wbeat_q + 3'd1;
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      wbeat_q <= '0;
      crc_q   <= '0;
      for (int i = 0; i < int'(MAX_OUT_BYTES); i++) pkt_buf_q[i] <= '0;
`ifdef PB_RLAST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      wbeat_q   <= wbeat_d;
      crc_q     <= crc_d;
      pkt_buf_q <= pkt_buf_d;
`ifdef PB_RLAST_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder: byte-level packet model plus per-cycle write-beat compare.
module tb_packet_builder;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  packet_builder_if bus ();

  packet_builder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef PB_RLAST_CHECK_EN
  localparam bit ErrOnBadRlast = 1'b1;
`else
  localparam bit ErrOnBadRlast = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q    [$];
  logic [31:0] exp_log  [$];
  logic [31:0] beat_log [$];
  logic [31:0] beats_q  [$];
  logic [32:0] cur;
  logic [7:0]  last_crc;
  int          exp_nb;
  int          hs_cnt      = 0;
  int          wstall      = 0;
  int          stall_cnt   = 0;
  int          cyc         = 0;
  int          last_hs_cyc = 0;
  bit          w_hs        = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // CRC as polynomial long division of the zero-augmented bit stream by x^8+x^2+x+1.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [8:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i <= msg.size(); i++) begin
      b = (i < msg.size()) ? msg[i] : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        r = {r[7:0], b[j]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction

  task automatic build_expect(input logic [3:0] bc, input logic [3:0] sel, input logic [7:0] id);
    logic [7:0]  b[$];
    logic [31:0] w;
    logic [31:0] word;
    int bpb, n, t;
    bpb = (sel == 4'd0) ? 1 : (sel == 4'd1) ? 2 : 4;
    n   = int'(bc) + 1;
    b.push_back({sel, bc});
    b.push_back(id);
    for (int i = 0; i < n; i++) begin
      w = beats_q[i / bpb];
      b.push_back(w[8*(i % bpb) +: 8]);
    end
    last_crc = model_crc(b);
    b.push_back(last_crc);
    t      = b.size();
    exp_nb = (t + 3) / 4;
    exp_log.delete();
    for (int j = 0; j < exp_nb; j++) begin
      word = '0;
      for (int l = 0; l < 4; l++) begin
        if (4*j + l < t) word[8*l +: 8] = b[4*j + l];
      end
      exp_q.push_back({(j == exp_nb - 1), word});
      exp_log.push_back(word);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write-side compare against the model on every cycle wvalid is high.
  always @(negedge clk) begin
    w_hs = (bus.wvalid === 1'b1) && (bus.wready === 1'b1);
    if (!reset && bus.wvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wvalid: got wdata 0x%08h, required no write beat", bus.wdata);
      end else begin
        cur = exp_q[0];
        check("wdata", bus.wdata, cur[31:0]);
        check("wlast", 32'(bus.wlast), 32'(cur[32]));
        if (bus.wready === 1'b1) begin
          void'(exp_q.pop_front());
          beat_log.push_back(bus.wdata);
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end
    end
  end

  // Write backpressure: hold wready low for wstall cycles at the start of every beat.
  always @(posedge clk) begin
    #1;
    if (w_hs || bus.wvalid !== 1'b1) stall_cnt = 0;
    if (bus.wvalid === 1'b1 && stall_cnt < wstall) begin
      bus.wready = 1'b0;
      stall_cnt++;
    end else begin
      bus.wready = (bus.wvalid === 1'b1);
    end
  end

  task automatic run_pkt(input logic [3:0] bc, input logic [3:0] sel, input logic [7:0] id,
                         input int rlast_idx, input int gaps, input int stall,
                         input bit exp_err, input bit do_reset);
    int tmo;
    bit got;
    beat_log.delete();
    hs_cnt = 0;
    wstall = stall;
    build_expect(bc, sel, id);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.byte_cnt = bc;
    bus.data_sel = sel;
    bus.pkt_id   = id;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.byte_cnt = ~bc;
    bus.pkt_id   = ~id;
    @(negedge clk);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("rready_after_start", 32'(bus.rready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < beats_q.size(); i++) begin
      bus.rvalid = 1'b0;
      if (gaps > 0) repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
      bus.rvalid = 1'b1;
      bus.rdata  = beats_q[i];
      bus.rlast  = (i == rlast_idx);
      got = 1'b0;
      tmo = 0;
      while (!got && tmo < 50) begin
        @(negedge clk);
        got = (bus.rready === 1'b1);
        @(posedge clk); #1;
        tmo++;
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL read_handshake: beat %0d not accepted, required rready within 50 cycles", i);
        bus.rvalid = 1'b0;
        return;
      end
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    @(negedge clk);
    check("wvalid_after_read", 32'(bus.wvalid), 32'd1);
    check("rready_after_read", 32'(bus.rready), 32'd0);
    if (stall > 0) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (do_reset) begin
      tmo = 0;
      while (hs_cnt < 2 && tmo < 200) begin @(negedge clk); tmo++; end
      check("reached_beat2", hs_cnt, 2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_wvalid", 32'(bus.wvalid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      return;
    end
    tmo = 0;
    while (bus.done !== 1'b1 && tmo < 400) begin @(negedge clk); tmo++; end
    check("done_seen", 32'(bus.done), 32'd1);
    check("done_latency", cyc - last_hs_cyc, 1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("beats_left", exp_q.size(), 0);
    check("beat_count", beat_log.size(), exp_nb);
    check("err", 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0]  m[$];
    logic [31:0] w;
    string       s;
    bus.start    = 1'b0;
    bus.byte_cnt = '0;
    bus.data_sel = '0;
    bus.pkt_id   = '0;
    bus.rdata    = '0;
    bus.rvalid   = 1'b0;
    bus.rlast    = 1'b0;
    bus.wready   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_rready", 32'(bus.rready), 32'd0);
    check("reset_wvalid", 32'(bus.wvalid), 32'd0);
    check("reset_wlast", 32'(bus.wlast), 32'd0);
    check("reset_wdata", bus.wdata, 32'h0);
    check("reset_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    s = "123456789";
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    check("model_crc_check_value", 32'(model_crc(m)), 32'hF4);
    m.delete();
    m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h01);
    check("model_crc_single_bit", 32'(model_crc(m)), 32'h07);

    // OP0, 1 byte of zero.
    beats_q.delete(); beats_q.push_back(32'h0000_0000);
    run_pkt(4'd0, 4'd0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    check("t1_model", exp_log[0], 32'h0000_0000);
    if (beat_log.size() == 1) check("t1_wdata", beat_log[0], 32'h0000_0000);

    // OP0, single byte 0x01.
    beats_q.delete(); beats_q.push_back(32'h0000_0001);
    run_pkt(4'd0, 4'd0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    check("t2_model", exp_log[0], 32'h0701_0000);
    if (beat_log.size() == 1) check("t2_wdata", beat_log[0], 32'h0701_0000);

    // OP2, 4 bytes in one beat.
    beats_q.delete(); beats_q.push_back(32'h4433_2211);
    run_pkt(4'd3, 4'd2, 8'h5A, 0, 0, 0, 1'b0, 1'b0);
    if (beat_log.size() == 2) begin
      check("t3_wdata0", beat_log[0], 32'h2211_5A23);
      w = beat_log[1];
      check("t3_wdata1_payload", 32'(w[15:0]), 32'h4433);
      check("t3_wdata1_crc", 32'(w[23:16]), 32'(last_crc));
      check("t3_wdata1_pad", 32'(w[31:24]), 32'h00);
    end

    // OP1, 16 bytes over 8 beats with read gaps and write stalls; upper halves are junk.
    beats_q.delete();
    for (int i = 0; i < 8; i++) beats_q.push_back({8'hA5, 8'(i) ^ 8'h3C, 8'(2*i + 1), 8'(2*i)});
    run_pkt(4'd15, 4'd1, 8'hE7, 7, 2, 3, 1'b0, 1'b0);
    if (beat_log.size() == 5) begin
      for (int k = 0; k < 16; k++) begin
        w = beat_log[(k + 2) / 4];
        check("t4_payload_pos", 32'(w[8*((k + 2) % 4) +: 8]), k);
      end
    end

    // OP0, 3 bytes with rlast asserted one beat early.
    beats_q.delete();
    beats_q.push_back(32'hFFFF_FF10);
    beats_q.push_back(32'hFFFF_FF20);
    beats_q.push_back(32'hFFFF_FF30);
    run_pkt(4'd2, 4'd0, 8'h33, 1, 0, 0, ErrOnBadRlast, 1'b0);
    if (beat_log.size() == 2) check("t5_wdata0", beat_log[0], 32'h2010_3302);

    // Reset during write beat 2, clearing sticky err too.
    beats_q.delete();
    for (int i = 0; i < 4; i++) beats_q.push_back({8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)});
    run_pkt(4'd15, 4'd2, 8'h81, 3, 0, 3, 1'b0, 1'b1);

    // Fresh packet after reset; the final read beat carries a byte that must be dropped.
    beats_q.delete();
    beats_q.push_back(32'h9999_0201);
    beats_q.push_back(32'h9999_0403);
    beats_q.push_back(32'h9999_7705);
    run_pkt(4'd4, 4'd1, 8'hC3, 2, 1, 1, 1'b0, 1'b0);
    if (beat_log.size() == 2) begin
      check("t7_wdata0", beat_log[0], 32'h0201_C314);
      w = beat_log[1];
      check("t7_wdata1_payload", 32'(w[23:0]), 32'h05_0403);
      check("t7_wdata1_crc", 32'(w[31:24]), 32'(last_crc));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
